// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one 32-bit barrel shifter between the
// operand-2 path (port 0) and the load/store scaled-offset path (port 1).
// The 5-bit core shifter is extended here to full register-specified shift
// semantics (8-bit amount, carry-out), and one result is held in an output
// register behind a valid/ready handshake.

// Logarithmic 5-bit barrel shifter. Left shifts are done as a right shift of
// the bit-reversed operand so a single right-shifting network serves all four
// shift types. The carry output is only meaningful for a nonzero amount.
module shift_core (
  input  logic [31:0] in_data,
  input  logic [4:0]  amount,
  input  logic [1:0]  shift_type,
  output logic [31:0] out_data,
  output logic        carry
);

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic        is_lsl;
  logic        is_ror;
  logic        fill_bit;
  logic [31:0] in_rev;
  logic [31:0] net_out;
  logic [31:0] net_rev;
  logic [31:0] stage [0:5];
  logic [4:0]  lsl_idx;
  logic [4:0]  rsh_idx;

  assign is_lsl   = (shift_type == LSL);
  assign is_ror   = (shift_type == ROR);
  // Only an arithmetic shift pulls in copies of the sign bit.
  assign fill_bit = (shift_type == ASR) && in_data[31];

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rev
      assign in_rev[gi]  = in_data[31-gi];
      assign net_rev[gi] = net_out[31-gi];
    end
  endgenerate

  assign stage[0] = is_lsl ? in_rev : in_data;

  // Stage gi conditionally shifts right by 2**gi; rotates wrap the low bits.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
      localparam int S = 1 << gi;
      logic [31:0] shifted;
      assign shifted = is_ror ? {stage[gi][S-1:0], stage[gi][31:S]}
                              : {{S{fill_bit}}, stage[gi][31:S]};
      assign stage[gi+1] = amount[gi] ? shifted : stage[gi];
    end
  endgenerate

  assign net_out  = stage[5];
  assign out_data = is_lsl ? net_rev : net_out;

  // Carry is the last bit shifted out: in[32-n] for left, in[n-1] otherwise.
  always_comb begin
    lsl_idx = 5'd0 - amount;
    rsh_idx = amount - 5'd1;
    carry   = 1'b0;
    if (amount != 5'd0) begin
      carry = is_lsl ? in_data[lsl_idx] : in_data[rsh_idx];
    end
  end

endmodule

module shift_arbiter (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_amount,
  input  logic [1:0]  req0_type,
  input  logic [31:0] req0_in,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_amount,
  input  logic [1:0]  req1_type,
  input  logic [31:0] req1_in,
  input  logic        req1_cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_carry,
  output logic        out_port
);

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q,  out_data_d;
  logic        out_carry_q, out_carry_d;
  logic        out_port_q,  out_port_d;
  logic        last_grant_q, last_grant_d;

  logic        accept;
  logic        grant;
  logic        handshake;

  logic [7:0]  sel_amount;
  logic [1:0]  sel_type;
  logic [31:0] sel_in;
  logic        sel_cin;

  logic [31:0] core_data;
  logic        core_carry;
  logic [31:0] res_data;
  logic        res_carry;

  // Round-robin grant and combinational ready; nothing is accepted in reset.
  always_comb begin
    accept = !out_valid_q || out_ready;
    if (req0_valid && req1_valid) begin
      grant = !last_grant_q;
    end else begin
      grant = req1_valid;
    end
    req0_ready = !Reset && accept && req0_valid && !grant;
    req1_ready = !Reset && accept && req1_valid && grant;
    handshake  = req0_ready || req1_ready;
  end

  // Route the granted port's fields to the shared shifter and extension logic.
  always_comb begin
    sel_amount = grant ? req1_amount : req0_amount;
    sel_type   = grant ? req1_type   : req0_type;
    sel_in     = grant ? req1_in     : req0_in;
    sel_cin    = grant ? req1_cin    : req0_cin;
  end

  shift_core u_shift_core (
    .in_data    (sel_in),
    .amount     (sel_amount[4:0]),
    .shift_type (sel_type),
    .out_data   (core_data),
    .carry      (core_carry)
  );

  // Extend the 5-bit shifter to the full 8-bit amount: zero amount passes the
  // operand and incoming carry; amounts of 32 and above saturate per type.
  always_comb begin
    res_data  = core_data;
    res_carry = core_carry;
    if (sel_amount == 8'd0) begin
      res_data  = sel_in;
      res_carry = sel_cin;
    end else begin
      unique case (sel_type)
        LSL: begin
          if (|sel_amount[7:5]) begin
            res_data  = 32'd0;
            res_carry = (sel_amount == 8'd32) ? sel_in[0] : 1'b0;
          end
        end
        LSR: begin
          if (|sel_amount[7:5]) begin
            res_data  = 32'd0;
            res_carry = (sel_amount == 8'd32) ? sel_in[31] : 1'b0;
          end
        end
        ASR: begin
          if (|sel_amount[7:5]) begin
            res_data  = {32{sel_in[31]}};
            res_carry = sel_in[31];
          end
        end
        ROR: begin
          // A nonzero multiple of 32 is a full rotation: data unchanged,
          // carry is the bit that wrapped last.
          if (sel_amount[4:0] == 5'd0) begin
            res_data  = sel_in;
            res_carry = sel_in[31];
          end
        end
        default: begin
          res_data  = core_data;
          res_carry = core_carry;
        end
      endcase
    end
  end

  // Output register: load on handshake, drain on out_ready, otherwise hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_carry_d  = out_carry_q;
    out_port_d   = out_port_q;
    last_grant_d = last_grant_q;
    if (handshake) begin
      out_valid_d  = 1'b1;
      out_data_d   = res_data;
      out_carry_d  = res_carry;
      out_port_d   = grant;
      last_grant_d = grant;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // State update; last_grant resets to 1 so port 0 wins the first contention.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'd0;
      out_carry_q  <= 1'b0;
      out_port_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_carry_q  <= out_carry_d;
      out_port_q   <= out_port_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign out_port  = out_port_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: vector table on both ports, a result
// scoreboard fed by a reference shift model, and hand-written sequences for
// contention, backpressure and reset during a stall.
module tb_shift_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req0_valid, req0_ready, req0_cin;
  logic [7:0]  req0_amount;
  logic [1:0]  req0_type;
  logic [31:0] req0_in;
  logic        req1_valid, req1_ready, req1_cin;
  logic [7:0]  req1_amount;
  logic [1:0]  req1_type;
  logic [31:0] req1_in;
  logic        out_valid, out_ready, out_carry, out_port;
  logic [31:0] out_data;

  always #5 CLK = ~CLK;

  shift_arbiter dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_amount (req0_amount),
    .req0_type   (req0_type),
    .req0_in     (req0_in),
    .req0_cin    (req0_cin),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_amount (req1_amount),
    .req1_type   (req1_type),
    .req1_in     (req1_in),
    .req1_cin    (req1_cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_carry   (out_carry),
    .out_port    (out_port)
  );

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        port;
  } exp_t;

  typedef struct {
    logic        port;
    logic [7:0]  amount;
    logic [1:0]  stype;
    logic [31:0] in;
    logic        cin;
    logic [31:0] exp_data;
    logic        exp_carry;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic last_hs0, last_hs1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Reference model built on wide shifts rather than a 5-bit network.
  function automatic logic [32:0] model(input logic [7:0] n, input logic [1:0] t,
                                        input logic [31:0] x, input logic c);
    logic [63:0]        w;
    logic signed [63:0] s;
    logic [31:0]        d;
    if (n == 8'd0) return {c, x};
    case (t)
      2'b00: begin w = {32'd0, x} << n; return {w[32], w[31:0]}; end
      2'b01: begin w = {x, 32'd0} >> n; return {w[31], w[63:32]}; end
      2'b10: begin s = $signed({x, 32'd0}) >>> n; return {s[31], s[63:32]}; end
      default: begin
        w = {x, x} >> n[4:0];
        d = w[31:0];
        return {d[31], d};
      end
    endcase
  endfunction

  // One cycle: sample at the falling edge, then return just after the rising
  // edge so the caller's new inputs apply to the following edge.
  task automatic tick();
    exp_t e;
    logic [32:0] m;
    @(negedge CLK);
    check("ready_exclusive", 32'(req0_ready && req1_ready), 32'd0);
    last_hs0 = req0_valid && req0_ready;
    last_hs1 = req1_valid && req1_ready;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        check("sb_data",  out_data,         sb_q[0].data);
        check("sb_carry", 32'(out_carry),   32'(sb_q[0].carry));
        check("sb_port",  32'(out_port),    32'(sb_q[0].port));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
    if (last_hs0) begin
      m = model(req0_amount, req0_type, req0_in, req0_cin);
      e.data = m[31:0]; e.carry = m[32]; e.port = 1'b0;
      sb_q.push_back(e);
    end
    if (last_hs1) begin
      m = model(req1_amount, req1_type, req1_in, req1_cin);
      e.data = m[31:0]; e.carry = m[32]; e.port = 1'b1;
      sb_q.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_port(input int p);
    if (p == 0) begin
      req0_amount = 8'($urandom_range(0, 70)); req0_type = 2'($urandom);
      req0_in = $urandom; req0_cin = 1'($urandom);
    end else begin
      req1_amount = 8'($urandom_range(0, 70)); req1_type = 2'($urandom);
      req1_in = $urandom; req1_cin = 1'($urandom);
    end
  endtask

  task automatic drain();
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("drained", 32'(sb_q.size()), 32'd0);
  endtask

  vec_t vecs[16];

  initial begin
    int  got, exp_port;
    logic done0, done1;

    vecs[0]  = '{0, 8'd4,   2'b00, 32'h8000_000F, 1'b0, 32'h0000_00F0, 1'b0};
    vecs[1]  = '{0, 8'd32,  2'b01, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2]  = '{0, 8'd40,  2'b10, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[3]  = '{0, 8'd33,  2'b00, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1, 8'd8,   2'b11, 32'h1234_5678, 1'b1, 32'h7812_3456, 1'b0};
    vecs[5]  = '{1, 8'd32,  2'b11, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0};
    vecs[6]  = '{0, 8'd0,   2'b01, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b1};
    vecs[7]  = '{1, 8'd32,  2'b00, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{0, 8'd4,   2'b10, 32'h8000_0010, 1'b1, 32'hF800_0001, 1'b0};
    vecs[9]  = '{1, 8'd1,   2'b01, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1};
    vecs[10] = '{0, 8'd4,   2'b11, 32'h0000_000F, 1'b0, 32'hF000_0000, 1'b1};
    vecs[11] = '{1, 8'd36,  2'b11, 32'h0000_000F, 1'b0, 32'hF000_0000, 1'b1};
    vecs[12] = '{0, 8'd200, 2'b01, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0};
    vecs[13] = '{1, 8'd0,   2'b10, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0};
    vecs[14] = '{0, 8'd31,  2'b00, 32'h0000_0003, 1'b0, 32'h8000_0000, 1'b1};
    vecs[15] = '{1, 8'd33,  2'b01, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0};

    Reset = 1'b1; out_ready = 1'b0;
    req0_valid = 1'b0; req0_amount = '0; req0_type = '0; req0_in = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_amount = '0; req1_type = '0; req1_in = '0; req1_cin = 1'b0;
    tick(); tick();
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    Reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_port",  32'(out_port),  32'd0);

    // Vector table, one port at a time, back-to-back with out_ready high.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      if (vecs[i].port == 1'b0) begin
        req0_valid = 1'b1; req0_amount = vecs[i].amount; req0_type = vecs[i].stype;
        req0_in = vecs[i].in; req0_cin = vecs[i].cin;
      end else begin
        req1_valid = 1'b1; req1_amount = vecs[i].amount; req1_type = vecs[i].stype;
        req1_in = vecs[i].in; req1_cin = vecs[i].cin;
      end
      got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
        tick();
        if ((vecs[i].port == 1'b0 && last_hs0) || (vecs[i].port == 1'b1 && last_hs1)) got = 1;
      end
      check("vec_handshake", 32'(got), 32'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_data", i),  out_data,       vecs[i].exp_data);
      check($sformatf("vec%0d_carry", i), 32'(out_carry), 32'(vecs[i].exp_carry));
      check($sformatf("vec%0d_port", i),  32'(out_port),  32'(vecs[i].port));
    end
    drain();

    // Contention from reset: grants alternate 0,1,0,1,...
    Reset = 1'b1; tick(); Reset = 1'b0;
    rand_port(0); rand_port(1);
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    exp_port = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("contend%0d_hs0", i), 32'(last_hs0), 32'(exp_port == 0));
      check($sformatf("contend%0d_hs1", i), 32'(last_hs1), 32'(exp_port == 1));
      if (last_hs0) rand_port(0);
      if (last_hs1) rand_port(1);
      exp_port = 1 - exp_port;
    end
    drain();

    // Backpressure: three stalled cycles, then both pending requests served.
    rand_port(0); req0_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("bp_load_hs0", 32'(last_hs0), 32'd1);
    rand_port(0); rand_port(1); req1_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_stall%0d_hs0", i), 32'(last_hs0), 32'd0);
      check($sformatf("bp_stall%0d_hs1", i), 32'(last_hs1), 32'd0);
      check($sformatf("bp_stall%0d_valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    done0 = 1'b0; done1 = 1'b0;
    for (int k = 0; k < 20 && !(done0 && done1); k++) begin
      tick();
      if (last_hs0) begin done0 = 1'b1; req0_valid = 1'b0; end
      if (last_hs1) begin done1 = 1'b1; req1_valid = 1'b0; end
    end
    check("bp_both_served", 32'({done0, done1}), 32'd3);
    drain();

    // Reset during a stall discards the held result; port 0 wins afterwards.
    rand_port(1); req1_valid = 1'b1; out_ready = 1'b1;
    tick();
    req1_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("stall_valid", 32'(out_valid), 32'd1);
    Reset = 1'b1; rand_port(0); rand_port(1); req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    check("rst_stall_hs0", 32'(last_hs0), 32'd0);
    check("rst_stall_hs1", 32'(last_hs1), 32'd0);
    Reset = 1'b0;
    sb_q.delete();
    check("rst_stall_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    tick();
    check("post_rst_grant0", 32'(last_hs0), 32'd1);
    req0_valid = 1'b0;
    tick();
    check("post_rst_hs1", 32'(last_hs1), 32'd1);
    req1_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so a wedged run still reports.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, failed count %0d", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the processor's single combinational barrel shifter between two requesters: port 0 is the data-processing operand-2 path and port 1 is the load/store scaled-offset path. The block round-robin arbitrates the ports and extends the 5-bit shifter to full ARM register-specified shift semantics (8-bit amount, carry-out). It registers one result at a time behind a valid/ready output handshake. It sits between the decode/operand-fetch stage and the ALU/address-generation inputs.

## Interface
- No parameters. Data width is fixed at 32 bits and amount width at 8 bits.
- CLK  in  1  sole clock; every register updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 has a shift request.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_amount  in  8  shift amount (Rs[7:0] or immediate).
- req0_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- req0_in  in  32  operand.
- req0_cin  in  1  current CPSR C flag.
- req1_valid, req1_ready, req1_amount, req1_type, req1_in, req1_cin: same as port 0, for port 1.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes the result this cycle.
- out_data  out  32  shifted value.
- out_carry  out  1  shifter carry-out.
- out_port  out  1  index of the port that produced the result.

## Operation
- Internal state:
  - output register {out_valid, out_data, out_carry, out_port};
  - last_grant (1 bit).
- accept = !out_valid || out_ready.
- Arbitration:
  - Only one requester valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - reqN_ready = accept && reqN_valid && (grant == N). This is combinational. At most one ready is high per cycle.
- On a handshake (reqN_valid && reqN_ready):
  - the output register loads the computed result, out_port = N, out_valid = 1;
  - last_grant = N.
- If out_ready is high and no request is accepted, out_valid clears.
- The shared shifter instance is driven with Amount = amount[4:0], Type = type, In = in from the granted port.
- Result rules, with n = amount:
  - n == 0, any type: data = in, carry = cin.
  - LSL 1..31: in << n, carry in[32-n]. LSL 32: 0, carry in[0]. LSL > 32: 0, carry 0.
  - LSR 1..31: in >> n, carry in[n-1]. LSR 32: 0, carry in[31]. LSR > 32: 0, carry 0.
  - ASR 1..31: arithmetic shift, carry in[n-1]. ASR >= 32: {32{in[31]}}, carry in[31].
  - ROR with n != 0 and n[4:0] == 0: data = in, carry in[31].
  - ROR otherwise: rotate by n[4:0], carry in[n[4:0]-1].
- While out_valid && !out_ready, all out_* fields hold stable.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_carry = 0, out_port = 0, last_grant = 1, so port 0 wins the first contention.
- Reset asserted mid-operation discards any held result. Both ready outputs are low during a Reset cycle.
- Latency: a request accepted in cycle N gives out_valid high in cycle N+1.
- Throughput: one result per cycle while out_ready stays high. The output register is reloaded in the same cycle it is drained.
- A request is not lost if not granted. The requester holds valid and its fields until it sees ready.
- req fields are sampled only in the handshake cycle.

## Test plan
- Port 0 only, LSL, n=4, in=0x8000_000F, cin=0 -> next cycle out_data=0x0000_00F0, out_carry=0, out_port=0.
- Boundary amounts:
  - LSR n=32, in=0x8000_0001 -> out_data=0, out_carry=1.
  - ASR n=40, in=0x8000_0000 -> out_data=0xFFFF_FFFF, out_carry=1.
  - LSL n=33 -> out_data=0, out_carry=0.
- Rotate and zero amount:
  - ROR n=8, in=0x1234_5678 -> out_data=0x7812_3456, out_carry=0.
  - ROR n=32, same in -> out_data=0x1234_5678, out_carry=0.
  - LSR n=0, cin=1 -> out_data=in, out_carry=1.
- Contention: both ports valid continuously with out_ready=1 from reset -> out_port sequence 0,1,0,1. Each port sees ready every other cycle.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged and both reqN_ready=0. Raising out_ready gives a new result the next cycle, with no lost or duplicated request.
- Reset mid-stall (out_valid=1, out_ready=0) -> out_valid=0 the cycle after Reset. First contention after reset grants port 0.
